// File: rtl/nna_pkg.sv
// Shared definitions for the neuron ALU: FSM encoding and datapath sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//   state_t       - neuron_alu FSM state encoding
//   prod_width()  - signed product width of one unsigned-by-signed multiply
//   acc_width()   - accumulator width, wide enough that fan_in products never overflow
//   res_width()   - width of (acc - threshold), one bit wider than acc
//   relu_max()    - ReLU saturation ceiling, 2^alu_width - 1
package nna_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACT  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // agg is zero-extended to alu_width+1 bits, so the product needs 2*alu_width+1 bits.
  function automatic int prod_width(input int alu_width);
    return 2 * alu_width + 1;
  endfunction

  // Summing fan_in products grows the magnitude by at most clog2(fan_in) bits.
  function automatic int acc_width(input int alu_width, input int fan_in);
    return 2 * alu_width + 1 + $clog2(fan_in);
  endfunction

  // acc minus a sign-extended threshold can exceed the acc range by one bit.
  function automatic int res_width(input int alu_width, input int fan_in);
    return acc_width(alu_width, fan_in) + 1;
  endfunction

  function automatic logic [63:0] relu_max(input int alu_width);
    return (64'd1 << alu_width) - 64'd1;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Multiply-accumulate: acc = load ? agg*weight : acc + agg*weight (agg unsigned, weight signed).
// Latency: result visible in acc one cycle after load/en.
// Backpressure: none; the caller qualifies every update with load or en.
//   clk, rst      - clock, synchronous active-high reset (clears acc)
//   load          - replace acc with the current product
//   en            - add the current product to acc (ignored when load=1)
//   agg, weight   - unsigned sample and two's-complement weight
//   acc           - signed running sum
module mac_unit
  import nna_pkg::*;
#(
  parameter int alu_width = 12,
  parameter int fan_in    = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        load,
  input  logic                                        en,
  input  logic [alu_width-1:0]                        agg,
  input  logic [alu_width-1:0]                        weight,
  output logic signed [acc_width(alu_width, fan_in)-1:0] acc
);

  localparam int W  = alu_width;
  localparam int PW = prod_width(alu_width);
  localparam int AW = acc_width(alu_width, fan_in);

  logic [PW-1:0]        agg_x;
  logic [PW-1:0]        weight_x;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_x;

  // Both operands are widened to the product width first: zero-extension keeps
  // agg unsigned, sign-extension keeps weight signed, and the PW-bit product
  // is exact because |agg*weight| < 2^(PW-1).
  assign agg_x    = {{(PW-W){1'b0}}, agg};
  assign weight_x = {{(PW-W){weight[W-1]}}, weight};
  assign prod     = $signed(agg_x) * $signed(weight_x);
  assign prod_x   = {{(AW-PW){prod[PW-1]}}, prod};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= prod_x;
    end else if (en) begin
      acc <= acc + prod_x;
    end
  end

endmodule

// File: rtl/neuron_alu.sv
// Neuron evaluation: accumulates fan_in weighted samples, subtracts a threshold, applies saturating ReLU.
// Latency: alu_valid rises two clock edges after the edge that accepts the last sample.
// Backpressure: in_ready=0 in ACT/HOLD; samples offered then are discarded and set sticky drop.
//   clk, rst          - clock, synchronous active-high reset
//   agg_in/agg_acted  - unsigned sample and its qualifier
//   weight_in         - two's-complement weight paired with agg_in
//   thresh_in         - two's-complement threshold, captured with the last sample
//   in_ready          - a qualified sample this cycle is accepted
//   alu_out/sat       - activated result and clip flag, valid with alu_valid
//   alu_valid/alu_ready - output handshake
//   drop              - sticky: a sample was offered while in_ready=0
module neuron_alu
  import nna_pkg::*;
#(
  parameter int alu_width = 12,
  parameter int fan_in    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [alu_width-1:0] agg_in,
  input  logic                 agg_acted,
  input  logic [alu_width-1:0] weight_in,
  input  logic [alu_width-1:0] thresh_in,
  output logic                 in_ready,
  output logic [alu_width-1:0] alu_out,
  output logic                 alu_valid,
  input  logic                 alu_ready,
  output logic                 sat,
  output logic                 drop
);

  localparam int W  = alu_width;
  localparam int AW = acc_width(alu_width, fan_in);
  localparam int RW = res_width(alu_width, fan_in);
  localparam int CW = $clog2(fan_in + 1);
  localparam logic signed [RW-1:0] RELU_MAX_R = RW'(relu_max(alu_width));
  localparam logic [CW-1:0]        CNT_LAST   = CW'(fan_in - 1);

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        cnt;
  logic [W-1:0]         thresh_q;
  logic signed [AW-1:0] acc;
  logic                 accept;
  logic                 last;
  logic                 mac_load;
  logic                 mac_en;
  logic signed [RW-1:0] res;
  logic [W-1:0]         act_out;
  logic                 act_sat;

  assign accept   = agg_acted && in_ready;
  // cnt holds the number already accepted, so this sample is the fan_in-th one.
  assign last     = (state == ACC) && accept && (cnt == CNT_LAST);
  assign mac_load = (state == IDLE) && accept;
  assign mac_en   = (state == ACC) && accept;

  mac_unit #(
    .alu_width(alu_width),
    .fan_in   (fan_in)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .load  (mac_load),
    .en    (mac_en),
    .agg   (agg_in),
    .weight(weight_in),
    .acc   (acc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)    state_nxt = ACC;
      ACC:  if (last)      state_nxt = ACT;
      ACT:                 state_nxt = HOLD;
      HOLD: if (alu_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready  = 1'b0;
    alu_valid = 1'b0;
    case (state)
      IDLE, ACC: in_ready  = 1'b1;
      HOLD:      alu_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        alu_valid = 1'b0;
      end
    endcase
  end

  // Activation: r = acc - thresh, then clamp to [0, 2^W-1].
  always_comb begin
    res     = {acc[AW-1], acc} - {{(RW-W){thresh_q[W-1]}}, thresh_q};
    act_out = '0;
    act_sat = 1'b0;
    if (res[RW-1] || (res == '0)) begin
      act_out = '0;
    end else if (res > RELU_MAX_R) begin
      act_out = '1;
      act_sat = 1'b1;
    end else begin
      act_out = res[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      thresh_q <= '0;
      alu_out  <= '0;
      sat      <= 1'b0;
      drop     <= 1'b0;
    end else begin
      if (mac_load) begin
        cnt <= CW'(1);
      end else if (last) begin
        cnt <= '0;
      end else if (mac_en) begin
        cnt <= cnt + CW'(1);
      end
      if (last) begin
        thresh_q <= thresh_in;
      end
      // Result registers load only in ACT, so they stay frozen through HOLD.
      if (state == ACT) begin
        alu_out <= act_out;
        sat     <= act_sat;
      end
      if (agg_acted && !in_ready) begin
        drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_neuron_alu.sv
// Directed self-checking bench for neuron_alu (alu_width=12, fan_in=8).
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_neuron_alu;

  localparam int W = 12;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] agg_in;
  logic         agg_acted;
  logic [W-1:0] weight_in;
  logic [W-1:0] thresh_in;
  logic         in_ready;
  logic [W-1:0] alu_out;
  logic         alu_valid;
  logic         alu_ready;
  logic         sat;
  logic         drop;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  neuron_alu #(.alu_width(W), .fan_in(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .agg_in   (agg_in),
    .agg_acted(agg_acted),
    .weight_in(weight_in),
    .thresh_in(thresh_in),
    .in_ready (in_ready),
    .alu_out  (alu_out),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .sat      (sat),
    .drop     (drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] w, input logic [W-1:0] t);
    agg_in    = a;
    weight_in = w;
    thresh_in = t;
    agg_acted = 1'b1;
    tick();
    agg_acted = 1'b0;
  endtask

  task automatic send_n(input logic [W-1:0] a, input logic [W-1:0] w, input logic [W-1:0] t);
    for (int i = 0; i < N; i++) send(a, w, t);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (alu_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; agg_acted = 1'b0; alu_ready = 1'b0;
    agg_in = '0; weight_in = '0; thresh_in = '0;
    tick(); tick();
    rst = 1'b0;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_tests++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_alu_valid: got %b expected 0", alu_valid); end
    n_tests++; if (alu_out !== 12'd0) begin n_fail++; $display("FAIL reset_alu_out: got %0d expected 0", alu_out); end
    n_tests++; if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b expected 0", sat); end
    n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b expected 0", drop); end
  endtask

  // 8 x (3*2) = 48, minus 10 = 38; checks exact two-edge latency and one-cycle valid.
  task automatic test_basic();
    alu_ready = 1'b1;
    send_n(12'd3, 12'd2, 12'd10);
    n_tests++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL basic_act_valid: got %b expected 0", alu_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_act_in_ready: got %b expected 0", in_ready); end
    tick();
    n_tests++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_valid: got %b expected 1", alu_valid); end
    n_tests++; if (alu_out !== 12'd38) begin n_fail++; $display("FAIL basic_out: got %0d expected 38", alu_out); end
    n_tests++; if (sat !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %b expected 0", sat); end
    tick();
    n_tests++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_one_cycle: got %b expected 0", alu_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_back_idle: got %b expected 1", in_ready); end
    n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL basic_drop: got %b expected 0", drop); end
  endtask

  // 8 x 4095 x 2047 = 67,059,720 far above 4095 -> clipped.
  task automatic test_saturate();
    bit ok;
    alu_ready = 1'b1;
    send_n(12'd4095, 12'd2047, 12'd0);
    wait_valid(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL sat_timeout: got no alu_valid expected alu_valid within 20 cycles"); end
    n_tests++; if (alu_out !== 12'd4095) begin n_fail++; $display("FAIL sat_out: got %0d expected 4095", alu_out); end
    n_tests++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag: got %b expected 1", sat); end
    tick();
  endtask

  // 8 x 5 x (-1) = -40 -> ReLU floor.
  task automatic test_negative();
    bit ok;
    alu_ready = 1'b1;
    send_n(12'd5, 12'hFFF, 12'd0);
    wait_valid(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL neg_timeout: got no alu_valid expected alu_valid within 20 cycles"); end
    n_tests++; if (alu_out !== 12'd0) begin n_fail++; $display("FAIL neg_out: got %0d expected 0", alu_out); end
    n_tests++; if (sat !== 1'b0) begin n_fail++; $display("FAIL neg_sat: got %b expected 0", sat); end
    tick();
  endtask

  // Downstream stalls 5 cycles while upstream keeps pushing samples.
  task automatic test_hold_backpressure();
    bit ok;
    alu_ready = 1'b0;
    send_n(12'd3, 12'd2, 12'd10);
    tick();
    n_tests++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b expected 1", alu_valid); end
    for (int i = 0; i < 5; i++) begin
      agg_in = 12'd100; weight_in = 12'd100; thresh_in = 12'd0; agg_acted = 1'b1;
      tick();
      n_tests++; if (alu_out !== 12'd38) begin n_fail++; $display("FAIL hold_out_stable[%0d]: got %0d expected 38", i, alu_out); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, in_ready); end
      n_tests++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid_stable[%0d]: got %b expected 1", i, alu_valid); end
    end
    agg_acted = 1'b0;
    n_tests++; if (drop !== 1'b1) begin n_fail++; $display("FAIL hold_drop: got %b expected 1", drop); end
    alu_ready = 1'b1;
    tick();
    n_tests++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %b expected 0", alu_valid); end
    send_n(12'd1, 12'd1, 12'd0);
    wait_valid(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL hold_next_timeout: got no alu_valid expected alu_valid within 20 cycles"); end
    n_tests++; if (alu_out !== 12'd8) begin n_fail++; $display("FAIL hold_next_out: got %0d expected 8", alu_out); end
    n_tests++; if (drop !== 1'b1) begin n_fail++; $display("FAIL hold_drop_sticky: got %b expected 1", drop); end
    tick();
  endtask

  // Abort a run mid-accumulation; the next run must start from a clean acc.
  task automatic test_reset_abort();
    bit ok;
    alu_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(12'd50, 12'd50, 12'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b expected 0", alu_valid); end
    n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL abort_drop_cleared: got %b expected 0", drop); end
    send_n(12'd1, 12'd1, 12'd0);
    wait_valid(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL abort_timeout: got no alu_valid expected alu_valid within 20 cycles"); end
    n_tests++; if (alu_out !== 12'd8) begin n_fail++; $display("FAIL abort_out: got %0d expected 8", alu_out); end
    tick();
  endtask

  // Idle cycles between samples must not advance the count or touch acc.
  task automatic test_gaps();
    bit ok;
    alu_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      send(12'd3, 12'd2, 12'd10);
      if (i < N - 1) begin
        agg_in = 12'hABC; weight_in = 12'h7FF;
        tick();
        n_tests++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL gap_valid[%0d]: got %b expected 0", i, alu_valid); end
      end
    end
    wait_valid(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL gap_timeout: got no alu_valid expected alu_valid within 20 cycles"); end
    n_tests++; if (alu_out !== 12'd38) begin n_fail++; $display("FAIL gap_out: got %0d expected 38", alu_out); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_negative();
    test_reset_abort();
    test_gaps();
    test_hold_backpressure();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_alu.md
NEURON_ALU -- requirements
Module: neuron_alu

Interface
REQ-001 SHALL have parameter alu_width, default 12, width of aggregator input, weight, threshold and output.
REQ-002 SHALL have parameter fan_in, default 8, number of accepted samples per neuron evaluation (legal range 2..256).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port agg_in  input  alu_width  unsigned aggregator count from the upstream calc stage.
REQ-006 SHALL have port agg_acted  input  1  qualifier; agg_in is a valid sample in any cycle where agg_acted=1.
REQ-007 SHALL have port weight_in  input  alu_width  two's-complement weight paired with the agg_in sample of the same cycle.
REQ-008 SHALL have port thresh_in  input  alu_width  two's-complement threshold, sampled on the final accepted sample.
REQ-009 SHALL have port in_ready  output  1  high when a sample presented this cycle will be accepted.
REQ-010 SHALL have port alu_out  output  alu_width  unsigned activated result.
REQ-011 SHALL have port alu_valid  output  1  alu_out is valid.
REQ-012 SHALL have port alu_ready  input  1  downstream accepts alu_out when alu_valid=1 and alu_ready=1.
REQ-013 SHALL have port sat  output  1  alu_out was clipped to its maximum; valid with alu_valid.
REQ-014 SHALL have port drop  output  1  sticky; set when agg_acted=1 while in_ready=0; cleared only by rst.

Function
REQ-015 SHALL implement FSM states IDLE, ACC, ACT, HOLD.
REQ-016 IDLE: in_ready=1; accepted sample loads acc = agg_in*weight_in, cnt=1, next ACC.
REQ-017 ACC: in_ready=1; accepted sample adds agg_in*weight_in to acc, cnt+1; if that sample is number fan_in, latch thresh_in and go to ACT; no sample -> stay, acc unchanged.
REQ-018 Multiply SHALL treat agg_in as unsigned (zero-extended) and weight_in as signed; product width 2*alu_width+1 signed.
REQ-019 acc width SHALL be 2*alu_width+1+clog2(fan_in) signed so no accumulate overflow is possible.
REQ-020 ACT (exactly one cycle, in_ready=0): r = acc - sign-extended thresh; r<=0 -> alu_out=0, sat=0; r>2^alu_width-1 -> alu_out=all ones, sat=1; else alu_out=r[alu_width-1:0], sat=0; next HOLD with alu_valid=1.
REQ-021 HOLD: in_ready=0; alu_out, sat, alu_valid stable until handshake; on alu_ready=1 go to IDLE with alu_valid=0 next cycle.
REQ-022 Latency: last sample edge -> alu_valid=1 after 2 rising edges (ACT register, then HOLD).
REQ-023 alu_ready while alu_valid=0 SHALL have no effect.
REQ-024 Samples presented in ACT or HOLD SHALL be discarded (not accumulated) and SHALL set drop.
REQ-025 alu_ready=1 in the first HOLD cycle SHALL complete the handshake in that cycle (min one-cycle HOLD).

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, acc=0, cnt=0, alu_out=0, alu_valid=0, sat=0, drop=0; in_ready=1 after reset.
REQ-027 rst mid-accumulation or in HOLD SHALL abandon the partial/pending result with no output pulse; rst has priority over all inputs.

Structure
REQ-028 FSM state encoding and the acc-width/ReLU-saturation constants SHALL live in shared package nna_pkg.
REQ-029 Multiply-accumulate datapath SHALL be one sub-module mac_unit (signed/unsigned multiply, accumulate, load/enable controls); FSM, activation and handshake in neuron_alu.

Verification
REQ-030 alu_width=12, fan_in=8: 8 samples agg_in=3, weight=2, thresh=10, alu_ready=1 -> alu_out=38, sat=0, alu_valid one cycle, 2 cycles after last sample.
REQ-031 8 samples agg_in=4095, weight=2047, thresh=0 -> alu_out=4095, sat=1.
REQ-032 8 samples agg_in=5, weight=-1 (0xFFF), thresh=0 -> alu_out=0, sat=0.
REQ-033 alu_ready held 0 for 5 cycles in HOLD, agg_acted=1 meanwhile -> alu_out stable, in_ready=0, drop=1, acc of next evaluation unaffected.
REQ-034 rst pulsed after 4 samples, then 8 samples agg_in=1, weight=1, thresh=0 -> alu_out=8 (no residue from aborted run).
REQ-035 Gaps: 8 samples with agg_acted toggling 1/0 -> same result as back-to-back; cnt advances only on accepted samples.
